therm_conditioner: RTL and testbench



---
 rtl/therm_conditioner.sv | 174 +++++++++++++++++
 tb/tb_therm_conditioner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/therm_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : therm_conditioner
//  Purpose  : Synchronizes raw flash-comparator bits, removes single-bit
//             bubbles, forces a monotone thermometer code and debounces it
//             before handing it to the thermometer-to-binary encoder.
//  Revision : 1.0 - initial release
// ============================================================================
module therm_conditioner #(
  parameter int WIDTH         = 7,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] comp_i,
  input  logic             sample_en_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] thermometer_o,
  output logic             enable_o,
  output logic             valid_o,
  output logic             bubble_err_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LOCK = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] therm_q, therm_d;
  logic             enable_q, enable_d;
  logic             valid_q, valid_d;
  logic             bubble_q, bubble_d;

  logic [WIDTH-1:0] s_w;
  logic [WIDTH+1:0] ext_w;
  logic [WIDTH-1:0] maj_w;
  logic [WIDTH-1:0] corr_w;
  logic             is_therm_w;

  // Shift the raw comparator bits through the metastability chain.
  always_comb begin
    sync_d[0] = comp_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s_w = sync_q[SYNC_STAGES-1];

  // Three-tap majority vote (padded with 1 below and 0 above) followed by a
  // prefix-AND, so any single flipped bit is repaired and the result is
  // always a legal thermometer code.
  always_comb begin
    ext_w = {1'b0, s_w, 1'b1};
    for (int k = 0; k < WIDTH; k++) begin
      maj_w[k] = (ext_w[k] & ext_w[k+1]) | (ext_w[k] & ext_w[k+2]) |
                 (ext_w[k+1] & ext_w[k+2]);
    end
    corr_w[0] = maj_w[0];
    for (int k = 1; k < WIDTH; k++) begin
      corr_w[k] = corr_w[k-1] & maj_w[k];
    end
  end

  // A legal code 0..01..1 plus one carries into a single clean bit.
  assign is_therm_w = ((s_w + WIDTH'(1)) & s_w) == '0;

  // Next-state logic: debounce FSM, output registers and the sticky bubble flag.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    therm_d  = therm_q;
    enable_d = enable_q;
    valid_d  = 1'b0;
    bubble_d = bubble_q;

    // Detection outranks clear so a live fault is never lost.
    if ((state_q != IDLE) && !is_therm_w) begin
      bubble_d = 1'b1;
    end else if (clear_i) begin
      bubble_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (sample_en_i) begin
          state_d = SETTLE;
          cand_d  = corr_w;
          cnt_d   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (!sample_en_i) begin
          state_d  = IDLE;
          enable_d = 1'b0;
        end else if (corr_w != cand_q) begin
          cand_d = corr_w;
          cnt_d  = CNT_W'(1);
        end else if (cnt_q == C_CNT_LOCK) begin
          therm_d  = cand_q;
          valid_d  = 1'b1;
          enable_d = 1'b1;
          state_d  = HOLD;
        end else if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        // Leaving for SETTLE keeps enable high; the old code stays valid
        // until the new one has proven stable.
        if (!sample_en_i) begin
          state_d  = IDLE;
          enable_d = 1'b0;
        end else if (corr_w != therm_q) begin
          state_d = SETTLE;
          cand_d  = corr_w;
          cnt_d   = CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      therm_q  <= '0;
      enable_q <= 1'b0;
      valid_q  <= 1'b0;
      bubble_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      therm_q  <= therm_d;
      enable_q <= enable_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
    end
  end

  assign thermometer_o = therm_q;
  assign enable_o      = enable_q;
  assign valid_o       = valid_q;
  assign bubble_err_o  = bubble_q;

endmodule
`default_nettype wire

// File: tb/tb_therm_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_therm_conditioner
//  Purpose  : Self-checking bench for therm_conditioner. A reference model
//             predicts every clock edge; a monitor compares the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_therm_conditioner;

  localparam int W      = 7;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] comp_i;
  logic         sample_en_i;
  logic         clear_i;
  logic [W-1:0] thermometer_o;
  logic         enable_o;
  logic         valid_o;
  logic         bubble_err_o;

  therm_conditioner #(
    .WIDTH        (W),
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .comp_i       (comp_i),
    .sample_en_i  (sample_en_i),
    .clear_i      (clear_i),
    .thermometer_o(thermometer_o),
    .enable_o     (enable_o),
    .valid_o      (valid_o),
    .bubble_err_o (bubble_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         v;
    logic [W-1:0] t;
    logic         e;
    logic         b;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------- model
  logic [W-1:0] hist[$];
  logic [W-1:0] m_out;
  logic         m_en;
  logic         m_bub;
  logic         m_hold;
  logic         m_prev_en;
  logic [W-1:0] m_run_val;
  int           m_run_len;

  // Thermometer code with n low ones.
  function automatic logic [W-1:0] ones_code(input int n);
    int r;
    r = (1 << n) - 1;
    return r[W-1:0];
  endfunction

  // Corrected code: length = first position whose 3-bit neighbourhood has
  // fewer than two ones (below bit 0 reads as 1, above the top reads as 0).
  function automatic logic [W-1:0] model_corr(input logic [W-1:0] s);
    int len;
    int votes;
    len = W;
    for (int k = 0; k < W; k++) begin
      votes = int'(s[k]);
      votes += (k == 0) ? 1 : int'(s[k-1]);
      votes += (k == W-1) ? 0 : int'(s[k+1]);
      if (votes < 2) begin
        len = k;
        break;
      end
    end
    return ones_code(len);
  endfunction

  function automatic logic model_is_therm(input logic [W-1:0] s);
    return s == ones_code($countones(s));
  endfunction

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < SYNC; i++) hist.push_back('0);
    m_out = '0; m_en = 1'b0; m_bub = 1'b0; m_hold = 1'b0;
    m_prev_en = 1'b0; m_run_val = '0; m_run_len = 0;
  endtask

  // Predict the DUT outputs right after the next rising edge.
  task automatic model_edge(input logic [W-1:0] c, input logic en,
                            input logic clr, output exp_t e);
    logic [W-1:0] s;
    logic [W-1:0] corr;
    logic         v;
    s = hist[0];
    void'(hist.pop_front());
    hist.push_back(c);
    corr = model_corr(s);
    v = 1'b0;
    if (m_prev_en && !model_is_therm(s)) m_bub = 1'b1;
    else if (clr)                        m_bub = 1'b0;
    if (!en) begin
      m_run_len = 0;
      m_hold    = 1'b0;
      m_en      = 1'b0;
    end else if (m_hold) begin
      if (corr != m_out) begin
        m_hold    = 1'b0;
        m_run_val = corr;
        m_run_len = 1;
      end
    end else begin
      if (m_run_len > 0 && corr == m_run_val) m_run_len++;
      else begin
        m_run_val = corr;
        m_run_len = 1;
      end
      if (m_run_len == STABLE) begin
        m_out  = m_run_val;
        v      = 1'b1;
        m_en   = 1'b1;
        m_hold = 1'b1;
      end
    end
    m_prev_en = en;
    e = '{v: v, t: m_out, e: m_en, b: m_bub};
  endtask

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a result, pop and compare it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_o", int'(valid_o), int'(e.v));
        chk("thermometer_o", int'(thermometer_o), int'(e.t));
        chk("enable_o", int'(enable_o), int'(e.e));
        chk("bubble_err_o", int'(bubble_err_o), int'(e.b));
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step(input logic [W-1:0] c, input logic en, input logic clr);
    exp_t e;
    @(negedge clk_i);
    comp_i      = c;
    sample_en_i = en;
    clear_i     = clr;
    model_edge(c, en, clr, e);
    exp_q.push_back(e);
  endtask

  task automatic hold_for(input logic [W-1:0] c, input logic en, input int n);
    for (int i = 0; i < n; i++) step(c, en, 1'b0);
  endtask

  task automatic drain();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    logic [W-1:0] c;
    logic         en;
    int           n;
    rst_i = 1'b1; comp_i = '0; sample_en_i = 1'b0; clear_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    chk("reset thermometer_o", int'(thermometer_o), 0);
    chk("reset enable_o", int'(enable_o), 0);
    chk("reset valid_o", int'(valid_o), 0);
    chk("reset bubble_err_o", int'(bubble_err_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Clean code lock from IDLE.
    hold_for(7'b0000111, 1'b1, 8);
    // Bubbled input, then clean input and a clear pulse.
    hold_for(7'b0001011, 1'b1, 8);
    hold_for(7'b0000111, 1'b1, 3);
    step(7'b0000111, 1'b1, 1'b1);
    hold_for(7'b0000111, 1'b1, 2);
    // Short glitch while holding.
    hold_for(7'b0000011, 1'b1, 8);
    hold_for(7'b0001111, 1'b1, 2);
    hold_for(7'b0000011, 1'b1, 10);
    // Full-scale step.
    hold_for(7'b0000001, 1'b1, 8);
    hold_for(7'b1111111, 1'b1, 8);
    // Abort mid-settle, then re-enable.
    hold_for(7'b0000111, 1'b1, 8);
    hold_for(7'b0001111, 1'b1, 3);
    hold_for(7'b0001111, 1'b0, 2);
    hold_for(7'b0001111, 1'b1, 8);
    drain();

    // Asynchronous reset while holding: outputs clear before any edge.
    #2;
    rst_i = 1'b1;
    #1;
    chk("async rst thermometer_o", int'(thermometer_o), 0);
    chk("async rst enable_o", int'(enable_o), 0);
    chk("async rst valid_o", int'(valid_o), 0);
    chk("async rst bubble_err_o", int'(bubble_err_o), 0);
    @(negedge clk_i);
    sample_en_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Randomized segments: mostly thermometer codes, some corrupted bits.
    for (int seg = 0; seg < 250; seg++) begin
      c = ones_code(int'($urandom_range(0, W)));
      if ($urandom_range(0, 4) == 0) c[$urandom_range(0, W-1)] ^= 1'b1;
      en = ($urandom_range(0, 9) != 0);
      n  = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) step(c, en, ($urandom_range(0, 9) == 0));
    end
    drain();
    chk("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
